// File: rtl/mem_refill_arbiter.sv
// mem_refill_arbiter
// Shares the single line-granular main-memory port between icache refills and
// dcache refills/writebacks. One transaction is in flight at a time: an address
// phase followed by BEATS data beats.
// Build option: define MEM_ARB_ROUND_ROBIN_EN to alternate the grant between
// simultaneous requesters; when undefined the dcache always wins a tie.
module mem_refill_arbiter #(
  parameter int unsigned ADDR_W = 28,
  parameter int unsigned DATA_W = 128,
  parameter int unsigned BEATS  = 4
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              ic_req_valid,
  input  logic [ADDR_W-1:0] ic_req_addr,
  output logic              ic_req_ready,
  output logic              ic_resp_valid,
  output logic [DATA_W-1:0] ic_resp_data,

  input  logic              dc_req_valid,
  input  logic              dc_req_rw,
  input  logic [ADDR_W-1:0] dc_req_addr,
  output logic              dc_req_ready,
  input  logic              dc_wdata_valid,
  input  logic [DATA_W-1:0] dc_wdata,
  output logic              dc_wdata_ready,
  output logic              dc_resp_valid,
  output logic [DATA_W-1:0] dc_resp_data,

  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_rw,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_wdata_valid,
  input  logic              mem_wdata_ready,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data,

  output logic              busy
);

  localparam int unsigned      CNT_W     = $clog2(BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  // Owner encoding: dcache is the reset / tie-break default.
  localparam logic OWN_DC = 1'b0;
  localparam logic OWN_IC = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WDATA = 2'd2,
    RDATA = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic              owner_q, owner_d;
  logic              mem_req_valid_q, mem_req_valid_d;
  logic              mem_req_rw_q, mem_req_rw_d;
  logic [ADDR_W-1:0] mem_req_addr_q, mem_req_addr_d;
  logic              busy_q, busy_d;
  logic              grant_ic;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic              last_grant_q, last_grant_d;
`endif

  // Pick the winner among requests present in IDLE
  always_comb begin
    grant_ic = 1'b0;
    if (ic_req_valid && !dc_req_valid) begin
      grant_ic = 1'b1;
    end
`ifdef MEM_ARB_ROUND_ROBIN_EN
    else if (ic_req_valid && dc_req_valid) begin
      // On a tie the requester that did not win last time goes first.
      grant_ic = (last_grant_q == OWN_DC);
    end
`endif
  end

  // Next state, latched request fields and combinational beat routing
  always_comb begin
    state_d         = state_q;
    beat_cnt_d      = beat_cnt_q;
    owner_d         = owner_q;
    mem_req_rw_d    = mem_req_rw_q;
    mem_req_addr_d  = mem_req_addr_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_grant_d    = last_grant_q;
`endif
    ic_req_ready    = 1'b0;
    dc_req_ready    = 1'b0;
    ic_resp_valid   = 1'b0;
    ic_resp_data    = '0;
    dc_resp_valid   = 1'b0;
    dc_resp_data    = '0;
    dc_wdata_ready  = 1'b0;
    mem_wdata_valid = 1'b0;
    mem_wdata       = '0;

    unique case (state_q)
      IDLE: begin
        if (ic_req_valid || dc_req_valid) begin
          owner_d        = grant_ic ? OWN_IC : OWN_DC;
          mem_req_rw_d   = grant_ic ? 1'b0 : dc_req_rw;
          mem_req_addr_d = grant_ic ? ic_req_addr : dc_req_addr;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_grant_d   = grant_ic ? OWN_IC : OWN_DC;
`endif
          state_d        = ISSUE;
        end
      end

      ISSUE: begin
        if (mem_req_ready) begin
          ic_req_ready = (owner_q == OWN_IC);
          dc_req_ready = (owner_q == OWN_DC);
          state_d      = mem_req_rw_q ? WDATA : RDATA;
        end
      end

      WDATA: begin
        // Writeback beats only ever come from the dcache.
        mem_wdata_valid = dc_wdata_valid;
        mem_wdata       = dc_wdata;
        dc_wdata_ready  = mem_wdata_ready;
        if (dc_wdata_valid && mem_wdata_ready) begin
          if (beat_cnt_q == LAST_BEAT) begin
            beat_cnt_d = '0;
            state_d    = IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end
        end
      end

      RDATA: begin
        if (owner_q == OWN_IC) begin
          ic_resp_valid = mem_resp_valid;
          ic_resp_data  = mem_resp_data;
        end else begin
          dc_resp_valid = mem_resp_valid;
          dc_resp_data  = mem_resp_data;
        end
        if (mem_resp_valid) begin
          if (beat_cnt_q == LAST_BEAT) begin
            beat_cnt_d = '0;
            state_d    = IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Address phase and busy are registered views of the next state.
    mem_req_valid_d = (state_d == ISSUE);
    busy_d          = (state_d != IDLE);
  end

  // State and registered-output flops; reset aborts any transaction in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      beat_cnt_q      <= '0;
      owner_q         <= OWN_DC;
      mem_req_valid_q <= 1'b0;
      mem_req_rw_q    <= 1'b0;
      mem_req_addr_q  <= '0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      beat_cnt_q      <= beat_cnt_d;
      owner_q         <= owner_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_req_rw_q    <= mem_req_rw_d;
      mem_req_addr_q  <= mem_req_addr_d;
      busy_q          <= busy_d;
    end
  end

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Remember who won the most recent grant
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= OWN_DC;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_rw    = mem_req_rw_q;
  assign mem_req_addr  = mem_req_addr_q;
  assign busy          = busy_q;

endmodule
